bcd_7seg_seq_conv: RTL

// - Sequential binary-to-BCD converter with a multi-digit 7-segment driver.
// - Generalises the fixed 4-bit/2-digit combinational decoder to BIN_W bits and DIGITS digits.
// - Uses a double-dabble engine (add-3, shift-left), one bit per clock, with a start/busy/done handshake.
// - Sits between lab datapath results (counters, ALU outputs) and the board's active-low 7-seg displays.

---
 rtl/bcd_7seg_seq_conv.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/bcd_7seg_seq_conv.sv
// bcd_7seg_seq_conv: sequential double-dabble binary-to-BCD converter with a
// multi-digit active-low 7-segment driver. One input bit is consumed per clock,
// and a start/busy/done handshake controls each conversion.
// Optional build macro BCD_LEADING_ZERO_BLANK_EN blanks leading zero digits
// (digit 0 is always shown). Without the macro, every digit displays its value.
module bcd_7seg_seq_conv #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [BIN_W-1:0]      bin,
    output logic                  busy,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd,
    output logic [7*DIGITS-1:0]   seg
);

    localparam int CNT_W = (BIN_W > 1) ? $clog2(BIN_W) : 1;
    localparam int BCD_W = 4 * DIGITS;
    localparam int SEG_W = 7 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;

    // True when DIGITS decimal digits can hold the largest BIN_W-bit value.
    function automatic bit range_ok(input int bw, input int dg);
        longint unsigned p;
        longint unsigned mx;
        bit              ok;
        p  = 64'd1;
        ok = 1'b0;
        mx = (bw >= 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << bw) - 64'd1);
        for (int i = 0; i < dg; i++) begin
            if (!ok) begin
                p = p * 64'd10;
                if (p > mx) ok = 1'b1;
            end
        end
        return ok;
    endfunction

    if (BIN_W < 1) begin : g_bad_bin_w
        $error("bcd_7seg_seq_conv: BIN_W must be >= 1");
    end
    if (!range_ok(BIN_W, DIGITS)) begin : g_bad_digits
        $error("bcd_7seg_seq_conv: DIGITS too small for BIN_W");
    end

    // Active-low segment pattern {g,f,e,d,c,b,a} for one BCD digit.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    seg_of = 7'b1000000;
            4'd1:    seg_of = 7'b1111001;
            4'd2:    seg_of = 7'b0100100;
            4'd3:    seg_of = 7'b0110000;
            4'd4:    seg_of = 7'b0011001;
            4'd5:    seg_of = 7'b0010010;
            4'd6:    seg_of = 7'b0000010;
            4'd7:    seg_of = 7'b1111000;
            4'd8:    seg_of = 7'b0000000;
            4'd9:    seg_of = 7'b0010000;
            default: seg_of = 7'b1111111;
        endcase
    endfunction

    typedef enum logic {
        S_IDLE = 1'b0,
        S_CONV = 1'b1
    } state_t;

    state_t             r_state;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   r_bcd;
    logic [SEG_W-1:0]   r_seg;
    logic [BIN_W-1:0]   r_shift;
    logic [BCD_W-1:0]   r_scratch;
    logic [CNT_W-1:0]   r_cnt;

    logic [BCD_W-1:0]   w_adj;
    logic [SR_W-1:0]    w_shifted;
    logic [BCD_W-1:0]   w_scratch_nx;
    logic [BIN_W-1:0]   w_shift_nx;
    logic [SEG_W-1:0]   w_seg_nx;
`ifdef BCD_LEADING_ZERO_BLANK_EN
    logic               w_hi_zero;
`endif

    // One double-dabble step: add 3 to every digit >= 5, then shift left by one.
    always_comb begin
        w_adj = r_scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5)
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
        end
        w_shifted    = {w_adj, r_shift} << 1;
        w_scratch_nx = w_shifted[BIN_W +: BCD_W];
        w_shift_nx   = w_shifted[BIN_W-1:0];
    end

    // Segment image of the step result; it is only latched on the final step.
    always_comb begin
        w_seg_nx = '1;
`ifdef BCD_LEADING_ZERO_BLANK_EN
        w_hi_zero = 1'b1;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
            w_seg_nx[7*i +: 7] = seg_of(w_scratch_nx[4*i +: 4]);
`ifdef BCD_LEADING_ZERO_BLANK_EN
            if (w_scratch_nx[4*i +: 4] != 4'd0)
                w_hi_zero = 1'b0;
            if ((i > 0) && w_hi_zero)
                w_seg_nx[7*i +: 7] = 7'b1111111;
`endif
        end
    end

    // Control FSM with registered outputs; results only move to bcd/seg on the last step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_bcd     <= '0;
            r_seg     <= '1;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_shift   <= bin;
                        r_scratch <= '0;
                        r_cnt     <= CNT_W'(BIN_W - 1);
                        r_busy    <= 1'b1;
                        r_state   <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_shift   <= w_shift_nx;
                    r_scratch <= w_scratch_nx;
                    r_cnt     <= r_cnt - CNT_W'(1);
                    if (r_cnt == '0) begin
                        r_bcd   <= w_scratch_nx;
                        r_seg   <= w_seg_nx;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign bcd  = r_bcd;
    assign seg  = r_seg;

endmodule
